// File: rtl/dly_sink_fifo.sv
// dly_sink_fifo
//   Credit-controlled sink buffer placed after a fixed-latency, non-stallable
//   delay chain. A credit is taken when the producer launches a word. It is
//   returned only when the consumer pops that word. Words still in the chain
//   therefore hold credits, so the FIFO cannot overflow.
//
// Ports
//   clk        clock, rising edge
//   rst        asynchronous active-high reset
//   issue_rdy  credit available (producer may launch this cycle)
//   issue_vld  producer launches a word into the delay chain
//   in_vld     a word exits the delay chain
//   in_data    data exiting the delay chain
//   out_vld    FIFO head valid
//   out_rdy    consumer accepts the head
//   out_data   FIFO head data
//   level      number of stored words
//   err        sticky flag: a word arrived with no word in flight
module dly_sink_fifo #(
  parameter int width = 1,
  parameter int depth = 4
) (
  input  logic                         clk,
  input  logic                         rst,
  output logic                         issue_rdy,
  input  logic                         issue_vld,
  input  logic                         in_vld,
  input  logic [width-1:0]             in_data,
  output logic                         out_vld,
  input  logic                         out_rdy,
  output logic [width-1:0]             out_data,
  output logic [$clog2(depth+1)-1:0]   level,
  output logic                         err
);

  localparam int lw = $clog2(depth+1);
  localparam int pw = $clog2(depth);

  logic [lw-1:0]    cred;
  logic [lw-1:0]    cnt;
  logic [pw-1:0]    wr_ptr;
  logic [pw-1:0]    rd_ptr;
  logic [width-1:0] mem [depth];

  logic issue_fire;
  logic pop;
  logic push;
  logic spurious;

  assign issue_rdy  = (cred < lw'(depth));
  assign out_vld    = (cnt != '0);
  assign out_data   = mem[rd_ptr];
  assign level      = cnt;

  assign issue_fire = issue_vld & issue_rdy;
  assign pop        = out_vld & out_rdy;
  // cred >= cnt always holds, so in-flight > 0 is simply cred > cnt.
  // The comparison uses pre-edge state. A same-cycle issue cannot cover
  // a same-cycle arrival.
  assign push       = in_vld & (cred > cnt);
  assign spurious   = in_vld & (cred == cnt);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cred   <= '0;
      cnt    <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      err    <= 1'b0;
    end else begin
      cred <= cred + lw'(issue_fire) - lw'(pop);
      cnt  <= cnt + lw'(push) - lw'(pop);
      if (push)
        wr_ptr <= wr_ptr + pw'(1);
      if (pop)
        rd_ptr <= rd_ptr + pw'(1);
      if (spurious)
        err <= 1'b1;
    end
  end

  // Storage is not reset. The head is don't-care while out_vld is low.
  always_ff @(posedge clk) begin
    if (push)
      mem[wr_ptr] <= in_data;
  end

endmodule

// File: tb/tb_dly_sink_fifo.sv
module tb_dly_sink_fifo;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  // ---------------- depth 4 instance ----------------
  logic       iss4_vld, rdy4, in4_vld, ovld4, ordy4, err4, spur4, fire4;
  logic [7:0] iss4_data, in4_data, odat4;
  logic [2:0] lvl4;
  logic [2:0] c4_v = '0;
  logic [7:0] c4_d [3];
  int         fires4 = 0;

  assign fire4    = iss4_vld & rdy4;
  assign in4_vld  = c4_v[2] | spur4;
  assign in4_data = c4_d[2];

  // delay chain, delaynum = 3, no reset
  always @(posedge clk) begin
    c4_v    <= {c4_v[1:0], fire4};
    c4_d[0] <= iss4_data;
    c4_d[1] <= c4_d[0];
    c4_d[2] <= c4_d[1];
    if (fire4) fires4 <= fires4 + 1;
  end

  dly_sink_fifo #(.width(8), .depth(4)) u_dut4 (
    .clk(clk), .rst(rst),
    .issue_rdy(rdy4), .issue_vld(iss4_vld),
    .in_vld(in4_vld), .in_data(in4_data),
    .out_vld(ovld4), .out_rdy(ordy4), .out_data(odat4),
    .level(lvl4), .err(err4)
  );

  // ---------------- depth 8 instance ----------------
  logic       iss8_vld, rdy8, in8_vld, ovld8, ordy8, err8, fire8;
  logic [7:0] iss8_data, in8_data, odat8;
  logic [3:0] lvl8;
  logic [2:0] c8_v = '0;
  logic [7:0] c8_d [3];
  int         fires8 = 0;

  assign fire8    = iss8_vld & rdy8;
  assign in8_vld  = c8_v[2];
  assign in8_data = c8_d[2];

  always @(posedge clk) begin
    c8_v    <= {c8_v[1:0], fire8};
    c8_d[0] <= iss8_data;
    c8_d[1] <= c8_d[0];
    c8_d[2] <= c8_d[1];
    if (fire8) fires8 <= fires8 + 1;
  end

  dly_sink_fifo #(.width(8), .depth(8)) u_dut8 (
    .clk(clk), .rst(rst),
    .issue_rdy(rdy8), .issue_vld(iss8_vld),
    .in_vld(in8_vld), .in_data(in8_data),
    .out_vld(ovld8), .out_rdy(ordy8), .out_data(odat8),
    .level(lvl8), .err(err8)
  );

  // ---------------- checking ----------------
  int n_run  = 0;
  int n_fail = 0;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_run++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  logic [7:0] exp_q [4];
  int         exp8, first8, last8;

  initial begin
    rst = 1'b1;
    iss4_vld = 0; iss4_data = 0; ordy4 = 0; spur4 = 0;
    iss8_vld = 0; iss8_data = 0; ordy8 = 0;
    step(); step();
    rst = 1'b0;
    step();

    // reset / idle
    chk("rst_issue_rdy", rdy4, 1);
    chk("rst_out_vld", ovld4, 0);
    chk("rst_level", lvl4, 0);
    chk("rst_err", err4, 0);
    chk("rst8_level", lvl8, 0);

    // fill: issue A..E with out_rdy=0, only four fire
    for (int k = 0; k < 5; k++) begin
      iss4_vld  = 1;
      iss4_data = 8'hA0 + 8'(k);
      step();
      if (k == 3) chk("fill_rdy_low_after_4th", rdy4, 0);
    end
    iss4_vld = 0;
    chk("fill_level_e5", lvl4, 2);
    chk("fill_head_a_e5", odat4, 8'hA0);
    step();
    chk("fill_level_e6", lvl4, 3);
    step();
    chk("fill_level_full", lvl4, 4);
    chk("fill_head_a_full", odat4, 8'hA0);
    chk("fill_out_vld", ovld4, 1);
    chk("fill_fires", fires4, 4);
    step(); step();
    chk("full_level_hold", lvl4, 4);
    chk("full_head_hold", odat4, 8'hA0);
    chk("full_rdy_low", rdy4, 0);
    chk("full_no_err", err4, 0);

    // single pop frees one credit
    ordy4 = 1;
    step();
    ordy4 = 0;
    chk("pop_rdy_back", rdy4, 1);
    chk("pop_level", lvl4, 3);
    chk("pop_head_b", odat4, 8'hA1);
    iss4_vld = 1; iss4_data = 8'hB0;
    step();
    iss4_vld = 0;
    chk("reissue_rdy_low", rdy4, 0);
    step(); step();
    chk("reissue_level_wait", lvl4, 3);
    step();
    chk("reissue_level_full", lvl4, 4);

    // drain in order B, C, D, new
    exp_q[0] = 8'hA1; exp_q[1] = 8'hA2; exp_q[2] = 8'hA3; exp_q[3] = 8'hB0;
    ordy4 = 1;
    for (int i = 0; i < 4; i++) begin
      chk("drain_vld", ovld4, 1);
      chk("drain_data", odat4, exp_q[i]);
      step();
    end
    ordy4 = 0;
    chk("drain_empty_vld", ovld4, 0);
    chk("drain_empty_level", lvl4, 0);
    chk("drain_rdy", rdy4, 1);

    // spurious arrival
    chk("spur_err_before", err4, 0);
    spur4 = 1;
    step();
    spur4 = 0;
    chk("spur_err_set", err4, 1);
    chk("spur_level", lvl4, 0);
    step(); step(); step();
    chk("spur_err_sticky", err4, 1);
    chk("spur_out_vld", ovld4, 0);

    // streaming on depth 8
    ordy8 = 1; exp8 = 0; first8 = -1; last8 = -1;
    for (int cyc = 0; cyc < 120; cyc++) begin
      if (ovld8) begin
        chk("stream_data", odat8, 8'(exp8));
        if (first8 < 0) first8 = cyc;
        last8 = cyc;
        exp8++;
      end
      chk("stream_level_le1", 32'(lvl8 <= 4'd1), 1);
      if (cyc < 100) begin
        chk("stream_issue_rdy", rdy8, 1);
        iss8_vld  = 1;
        iss8_data = 8'(cyc);
      end else begin
        iss8_vld = 0;
      end
      step();
    end
    chk("stream_count", exp8, 100);
    chk("stream_contiguous", last8 - first8 + 1, 100);
    chk("stream_fires", fires8, 100);
    chk("stream_empty", ovld8, 0);
    chk("stream_err", err8, 0);

    // reset with 2 stored, 2 in flight
    rst = 1; step(); rst = 0; step();
    chk("rr_err_clear", err4, 0);
    for (int k = 0; k < 4; k++) begin
      iss4_vld  = 1;
      iss4_data = 8'hC0 + 8'(k);
      step();
    end
    iss4_vld = 0;
    chk("rr_level_1", lvl4, 1);
    step();
    chk("rr_level_2", lvl4, 2);
    rst = 1;
    #1;
    chk("rr_async_rdy", rdy4, 1);
    chk("rr_async_vld", ovld4, 0);
    chk("rr_async_level", lvl4, 0);
    chk("rr_async_err", err4, 0);
    #1;
    rst = 0;
    step();
    chk("rr_late1_err", err4, 1);
    chk("rr_late1_level", lvl4, 0);
    step();
    chk("rr_late2_err", err4, 1);
    chk("rr_late2_level", lvl4, 0);
    chk("rr_late2_rdy", rdy4, 1);

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
